// File: rtl/circuit1_sweep_ctrl.sv
// rtl/circuit1_sweep_ctrl.sv - exhaustive 16-vector sweep sequencer for circuit1
//
// Purpose:
//   On an accepted start, drives every {A,B,C,D} combination into circuit1 in
//   ascending order. Each vector is held for SETTLE_CYCLES cycles and then
//   sampled for one cycle. The sampled X values form a 16-entry truth table,
//   which is compared against an expected mask captured at start.
//
// Parameters:
//   SETTLE_CYCLES  hold cycles per vector before sampling (0 behaves as 1)
//
// Ports:
//   clk           in   system clock, rising edge
//   rst           in   synchronous active-high reset
//   start         in   begin a sweep (accepted only when idle)
//   expected[15:0] in  expected X per vector, captured on accepted start
//   x_in          in   X output of circuit1
//   a_out..d_out  out  vector bits 3..0 to circuit1
//   busy          out  sweep in progress
//   done          out  one-cycle completion pulse
//   truth_table   out  sampled X, bit i = vector i
//   mismatch_cnt  out  count of bits differing from expected (0..16)
//   pass          out  no mismatches in the last completed sweep

module circuit1_sweep_ctrl #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] expected,
    input  logic        x_in,
    output logic        a_out,
    output logic        b_out,
    output logic        c_out,
    output logic        d_out,
    output logic        busy,
    output logic        done,
    output logic [15:0] truth_table,
    output logic [4:0]  mismatch_cnt,
    output logic        pass
);

    localparam int S_EFF = (SETTLE_CYCLES < 1) ? 1 : SETTLE_CYCLES;
    localparam int CW    = (S_EFF > 1) ? $clog2(S_EFF) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(S_EFF - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      idx_q, idx_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [15:0]     exp_q, exp_d;
    logic [15:0]     tt_q, tt_d;
    logic [4:0]      mm_q, mm_d;
    logic [3:0]      vec_q, vec_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            pass_q, pass_d;
    logic            bit_miss;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= 4'd0;
            cnt_q   <= '0;
            exp_q   <= 16'd0;
            tt_q    <= 16'd0;
            mm_q    <= 5'd0;
            vec_q   <= 4'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            exp_q   <= exp_d;
            tt_q    <= tt_d;
            mm_q    <= mm_d;
            vec_q   <= vec_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (start) state_d = ST_SETTLE;
            ST_SETTLE: if (cnt_q == CNT_LAST) state_d = ST_SAMPLE;
            ST_SAMPLE: state_d = (idx_q == 4'd15) ? ST_DONE : ST_SETTLE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    assign bit_miss = (x_in != exp_q[idx_q]);

    // Output and datapath next values
    always_comb begin
        idx_d  = idx_q;
        cnt_d  = cnt_q;
        exp_d  = exp_q;
        tt_d   = tt_q;
        mm_d   = mm_q;
        pass_d = pass_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    exp_d = expected;
                    tt_d  = 16'd0;
                    mm_d  = 5'd0;
                    idx_d = 4'd0;
                    cnt_d = '0;
                end
            end
            ST_SETTLE: begin
                if (cnt_q != CNT_LAST) cnt_d = cnt_q + 1'b1;
            end
            ST_SAMPLE: begin
                tt_d[idx_q] = x_in;
                mm_d        = mm_q + {4'd0, bit_miss};
                if (idx_q == 4'd15) begin
                    // pass must be valid in the same cycle as done, so it
                    // is taken from the count including the final sample
                    pass_d = (mm_d == 5'd0);
                end else begin
                    idx_d = idx_q + 4'd1;
                    cnt_d = '0;
                end
            end
            default: ;
        endcase

        // Registered outputs are derived from the upcoming state so they
        // line up with the state they describe.
        vec_d  = (state_d == ST_SETTLE || state_d == ST_SAMPLE) ? idx_d : 4'd0;
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    assign {a_out, b_out, c_out, d_out} = vec_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign truth_table  = tt_q;
    assign mismatch_cnt = mm_q;
    assign pass         = pass_q;

endmodule

// File: tb/tb_circuit1_sweep_ctrl.sv
// tb/tb_circuit1_sweep_ctrl.sv - randomized self-checking bench for circuit1_sweep_ctrl
module tb_circuit1_sweep_ctrl;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, x_in;
    logic [15:0] expected;
    logic        a_out, b_out, c_out, d_out, busy, done, pass;
    logic [15:0] truth_table;
    logic [4:0]  mismatch_cnt;

    logic        start2, x2;
    logic [15:0] expected2;
    logic        a2, b2, c2, d2, busy2, done2, pass2;
    logic [15:0] tt2;
    logic [4:0]  mm2;

    logic [15:0] model_q;
    logic        glitch_en, glitch_val;

    int n_checks = 0;
    int n_errors = 0;

    // circuit1 stand-in: truth-table lookup, with optional glitching
    assign x_in = glitch_en ? glitch_val : model_q[{a_out, b_out, c_out, d_out}];
    assign x2   = ~d2;

    circuit1_sweep_ctrl #(.SETTLE_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .start(start), .expected(expected), .x_in(x_in),
        .a_out(a_out), .b_out(b_out), .c_out(c_out), .d_out(d_out),
        .busy(busy), .done(done), .truth_table(truth_table),
        .mismatch_cnt(mismatch_cnt), .pass(pass)
    );

    circuit1_sweep_ctrl #(.SETTLE_CYCLES(0)) dut_s0 (
        .clk(clk), .rst(rst), .start(start2), .expected(expected2), .x_in(x2),
        .a_out(a2), .b_out(b2), .c_out(c2), .d_out(d2),
        .busy(busy2), .done(done2), .truth_table(tt2),
        .mismatch_cnt(mm2), .pass(pass2)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp_v);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_vec"},  32'({a_out, b_out, c_out, d_out}), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_tt"},   32'(truth_table), 32'd0);
        chk({tag, "_mm"},   32'(mismatch_cnt), 32'd0);
        chk({tag, "_pass"}, 32'(pass), 32'd0);
    endtask

    // One S=2 sweep. Reference: vector i occupies cycles 1+3i..3+3i and is
    // sampled in the last of them; results appear with done at cycle 49.
    task automatic sweep(input logic [15:0] model, input logic [15:0] exp_v, input bit noise);
        int dones;
        logic [3:0] vec;
        int exp_mm;
        exp_mm = $countones(model ^ exp_v);
        dones  = 0;
        @(negedge clk);
        model_q  = model;
        expected = exp_v;
        start    = 1'b1;
        for (int cyc = 1; cyc <= 52; cyc++) begin
            @(negedge clk);
            vec   = {a_out, b_out, c_out, d_out};
            start = noise && (cyc == 10 || cyc == 48);
            if (noise) expected = 16'($urandom);
            if (done) dones++;
            if (cyc <= 48) begin
                chk("vec", 32'(vec), 32'((cyc - 1) / 3));
                chk("busy", 32'(busy), 32'd1);
                glitch_en  = noise && ((cyc - 1) % 3 != 2) && ($urandom_range(0, 1) == 1);
                glitch_val = 1'($urandom_range(0, 1));
            end else begin
                glitch_en = 1'b0;
            end
            if (cyc == 49) begin
                chk("done", 32'(done), 32'd1);
                chk("busy_done", 32'(busy), 32'd1);
                chk("tt", 32'(truth_table), 32'(model));
                chk("mm", 32'(mismatch_cnt), 32'(exp_mm));
                chk("pass", 32'(pass), 32'(exp_mm == 0));
            end
            if (cyc == 50) begin
                chk("busy_after", 32'(busy), 32'd0);
                chk("vec_after", 32'(vec), 32'd0);
            end
        end
        chk("tt_held", 32'(truth_table), 32'(model));
        chk("done_pulses", 32'(dones), 32'd1);
    endtask

    task automatic reset_test();
        int dones;
        dones = 0;
        @(negedge clk);
        model_q  = 16'($urandom);
        expected = 16'hFFFF;
        start    = 1'b1;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) dones++;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_reset_vals("midrst");
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            if (done) dones++;
        end
        chk("rst_no_done", 32'(dones), 32'd0);
    endtask

    task automatic held_start_test();
        @(negedge clk);
        model_q  = 16'h8000;
        expected = 16'h8000;
        start    = 1'b1;
        for (int cyc = 1; cyc <= 51; cyc++) begin
            @(negedge clk);
            if (cyc == 49) chk("held_done", 32'(done), 32'd1);
            if (cyc == 50) chk("held_idle", 32'(busy), 32'd0);
            if (cyc == 51) chk("held_rebusy", 32'(busy), 32'd1);
        end
        start = 1'b0;
        rst   = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
        chk("held_abort", 32'(busy), 32'd0);
    endtask

    // S=0 build behaves as S=1: vector i in cycles 1+2i..2+2i, done at 33.
    task automatic sweep_s0(input logic [15:0] exp_v);
        int dones;
        int exp_mm;
        exp_mm = $countones(16'h5555 ^ exp_v);
        dones  = 0;
        @(negedge clk);
        expected2 = exp_v;
        start2    = 1'b1;
        for (int cyc = 1; cyc <= 36; cyc++) begin
            @(negedge clk);
            start2 = 1'b0;
            if (done2) dones++;
            if (cyc <= 32) chk("s0_vec", 32'({a2, b2, c2, d2}), 32'((cyc - 1) / 2));
            if (cyc == 33) begin
                chk("s0_done", 32'(done2), 32'd1);
                chk("s0_tt", 32'(tt2), 32'h5555);
                chk("s0_mm", 32'(mm2), 32'(exp_mm));
                chk("s0_pass", 32'(pass2), 32'(exp_mm == 0));
            end
        end
        chk("s0_done_pulses", 32'(dones), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        start2     = 1'b0;
        expected   = 16'd0;
        expected2  = 16'd0;
        model_q    = 16'd0;
        glitch_en  = 1'b0;
        glitch_val = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        rst = 1'b0;

        sweep(16'h8000, 16'h8000, 1'b0);
        sweep(16'h8000, 16'h0000, 1'b0);
        sweep(16'h8000, 16'h8000, 1'b0);
        reset_test();
        sweep(16'h8000, 16'h8000, 1'b1);
        for (int k = 0; k < 4; k++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            sweep(16'($urandom), 16'($urandom), 1'b1);
        end
        sweep(16'hFFFF, 16'h0000, 1'b1);
        held_start_test();
        sweep_s0(16'h5555);
        sweep_s0(16'($urandom));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
